uart_fifo_core: RTL and testbench
=================================

Name: uart_fifo_core

Overview:
- Parametrised full-duplex UART engine: one clock domain, internal baud generation, configurable frame width, TX and RX FIFOs, sticky error flags.
- Sits between the CPU peripheral bus decoder and the board RX/TX pins.
- Provides buffering and error reporting through a byte-level push/pop interface.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, baud ticks per bit; even value, at least 8.
- DATA_BITS, 8, payload bits per frame; range 5 to 9.
- FIFO_DEPTH, 4, entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output, idles high.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_wr  in  1  one-cycle push of tx_data into the TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  high when the TX FIFO is non-empty or a frame is on the line.
- rx_data  out  DATA_BITS  head of the RX FIFO (first-word fall-through).
- rx_rd  in  1  one-cycle pop of the RX FIFO.
- rx_empty  out  1  RX FIFO empty.
- rx_overrun  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- rx_frame_err  out  1  sticky: a stop bit was sampled low.
- err_clr  in  1  one-cycle clear of all sticky error flags.

Behaviour:
- Reset, synchronous, active-high. On the first clk edge with reset=1:
  - tx=1, tx_busy=0, tx_full=0, rx_empty=1, rx_data=0, all error flags 0.
  - Both FIFOs are flushed.
  - Both engines return to IDLE, even mid-frame; a partial frame is lost.
- Baud tick:
  - Free-running counter, divisor DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), minimum 1.
  - The tick is a one-cycle pulse, shared by TX and RX.
- TX FIFO:
  - tx_wr while tx_full=1 is ignored and the data is lost.
  - A push becomes visible to the engine on the next cycle.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty, the engine pops the head and enters START at the next tick.
  - Each bit lasts OVERSAMPLE ticks.
  - START drives 0. DATA sends DATA_BITS bits, LSB first. STOP drives 1.
  - When the FIFO is non-empty at the end of STOP, the next START begins with no extra idle bit (back-to-back frames).
- RX synchroniser and glitch filter:
  - rx passes through a 2-flop synchroniser before any use.
  - IDLE detects a 1->0 transition on the synchronised line.
  - START re-samples at tick OVERSAMPLE/2. If the line is high again, the event is a glitch and the FSM returns to IDLE with no flag set.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Data bits are sampled mid-bit, every OVERSAMPLE ticks, LSB first.
  - STOP sample = 0: set rx_frame_err, discard the byte, then wait for the line to go high before re-arming.
  - STOP sample = 1 and FIFO not full: push the byte.
  - STOP sample = 1 and FIFO full: drop the byte and set rx_overrun.
- RX FIFO:
  - rx_data shows the head whenever rx_empty=0.
  - rx_rd while rx_empty=1 is ignored.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - rx_empty and rx_data update one cycle after a push.
- Error flags:
  - err_clr clears the flags.
  - If err_clr and a new error occur in the same cycle, the flag ends up set.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full: MSBs differ and the other bits are equal.
  - empty: pointers are equal.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP in both FSMs. It carries an even parity bit.
  - Adds output rx_parity_err (1 bit, sticky, cleared by err_clr, reset 0).
  - A received parity mismatch sets rx_parity_err and discards the byte.
  - A parity mismatch with a bad stop bit sets both rx_parity_err and rx_frame_err.
- Undefined: no PARITY state and no rx_parity_err port. Frame = start + DATA_BITS + stop.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=16000000, BAUD=1000000, OVERSAMPLE=16, so DIV=1 and one bit = 16 clk cycles.
- TX frame: tx_wr with 0xA5 -> tx low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high. tx_busy=1 from the cycle after the write until the stop bit ends.
- Loopback with tx tied to rx: write 0x00, 0xFF, 0x3C back-to-back -> tx_full never asserts. rx_data reads 0x00, 0xFF, 0x3C in order. No error flags set.
- Overrun: drive 5 frames into rx with no rx_rd -> rx_overrun=1 after frame 5. Four pops return frames 1 to 4. rx_empty=1 after the 4th pop.
- Framing error and glitch:
  - Frame of 0x55 with stop bit 0 -> rx_frame_err=1, rx_empty stays 1.
  - A 4-cycle low pulse on rx -> no push, no flag.
- Reset mid-frame: assert reset during TX bit 3 with 2 bytes queued -> tx=1, tx_busy=0, tx_full=0 on the next edge. No further bits are emitted.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with shared baud tick, TX/RX FIFOs and
// sticky error flags. Define UART_PARITY_EN to add an even parity bit to
// every frame and the rx_parity_err output.
module uart_fifo_core #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
`ifdef UART_PARITY_EN
  output logic                 rx_parity_err,
`endif
  input  logic                 err_clr
);

  localparam longint BAUD_OS = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam longint DIV_RAW = (longint'(CLK_HZ) + BAUD_OS / 64'sd2) / BAUD_OS;
  localparam int DIV   = (DIV_RAW < 64'sd1) ? 32'sd1 : int'(DIV_RAW);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

`ifdef UART_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] baud_cnt_r;
  logic             tick_s;
  assign tick_s = (baud_cnt_r == DIV_W'(DIV - 1));

  // Free-running divider producing a one-cycle tick every DIV clocks.
  always_ff @(posedge clk) begin
    if (reset || tick_s) baud_cnt_r <= {DIV_W{1'b0}};
    else                 baud_cnt_r <= baud_cnt_r + DIV_W'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        tx_wp_r, tx_rp_r;
  logic                 tx_empty_s, tx_push_s, tx_pop_s;
  logic [DATA_BITS-1:0] tx_head_s;

  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_full    = (tx_wp_r[AW] != tx_rp_r[AW]) && (tx_wp_r[AW-1:0] == tx_rp_r[AW-1:0]);
  assign tx_push_s  = tx_wr && !tx_full;
  assign tx_head_s  = tx_mem_r[tx_rp_r[AW-1:0]];

  // TX FIFO storage write; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wp_r[AW-1:0]] <= tx_data;
  end

  // TX FIFO pointers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_r <= {PW{1'b0}};
      tx_rp_r <= {PW{1'b0}};
    end else begin
      if (tx_push_s) tx_wp_r <= tx_wp_r + PW'(1);
      if (tx_pop_s)  tx_rp_r <= tx_rp_r + PW'(1);
    end
  end

  // ---------------- TX engine ----------------
  logic [2:0]           tx_state_r;
  logic [OS_W-1:0]      tx_os_r;
  logic [BIT_W-1:0]     tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_r;
  logic                 tx_bit_end_s;
`ifdef UART_PARITY_EN
  logic                 tx_par_r;
`endif

  assign tx_bit_end_s = tick_s && (tx_os_r == OS_W'(OVERSAMPLE - 1));
  assign tx      = tx_r;
  assign tx_busy = !tx_empty_s || (tx_state_r != S_IDLE);

  // Engine takes the FIFO head when idle on a tick, or straight out of STOP
  // so queued frames go out back-to-back.
  always_comb begin
    tx_pop_s = 1'b0;
    case (tx_state_r)
      S_IDLE:  tx_pop_s = tick_s && !tx_empty_s;
      S_STOP:  tx_pop_s = tx_bit_end_s && !tx_empty_s;
      default: tx_pop_s = 1'b0;
    endcase
  end

  // TX frame sequencer; tx_r is registered so the pin never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= S_IDLE;
      tx_os_r    <= {OS_W{1'b0}};
      tx_bit_r   <= {BIT_W{1'b0}};
      tx_shift_r <= {DATA_BITS{1'b0}};
      tx_r       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_r   <= 1'b0;
`endif
    end else begin
      case (tx_state_r)
        S_IDLE: begin
          tx_r <= 1'b1;
          if (tx_pop_s) begin
            tx_shift_r <= tx_head_s;
`ifdef UART_PARITY_EN
            tx_par_r   <= even_parity(tx_head_s);
`endif
            tx_os_r    <= {OS_W{1'b0}};
            tx_r       <= 1'b0;
            tx_state_r <= S_START;
          end
        end
        S_START: begin
          if (tx_bit_end_s) begin
            tx_os_r    <= {OS_W{1'b0}};
            tx_bit_r   <= {BIT_W{1'b0}};
            tx_r       <= tx_shift_r[0];
            tx_state_r <= S_DATA;
          end else if (tick_s) tx_os_r <= tx_os_r + OS_W'(1);
        end
        S_DATA: begin
          if (tx_bit_end_s) begin
            tx_os_r <= {OS_W{1'b0}};
            if (tx_bit_r == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_r       <= tx_par_r;
              tx_state_r <= S_PARITY;
`else
              tx_r       <= 1'b1;
              tx_state_r <= S_STOP;
`endif
            end else begin
              tx_bit_r   <= tx_bit_r + BIT_W'(1);
              tx_shift_r <= tx_shift_r >> 1;
              tx_r       <= tx_shift_r[1];
            end
          end else if (tick_s) tx_os_r <= tx_os_r + OS_W'(1);
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (tx_bit_end_s) begin
            tx_os_r    <= {OS_W{1'b0}};
            tx_r       <= 1'b1;
            tx_state_r <= S_STOP;
          end else if (tick_s) tx_os_r <= tx_os_r + OS_W'(1);
        end
`endif
        S_STOP: begin
          if (tx_bit_end_s) begin
            tx_os_r <= {OS_W{1'b0}};
            if (tx_pop_s) begin
              tx_shift_r <= tx_head_s;
`ifdef UART_PARITY_EN
              tx_par_r   <= even_parity(tx_head_s);
`endif
              tx_r       <= 1'b0;
              tx_state_r <= S_START;
            end else begin
              tx_state_r <= S_IDLE;
            end
          end else if (tick_s) tx_os_r <= tx_os_r + OS_W'(1);
        end
        default: begin
          tx_r       <= 1'b1;
          tx_state_r <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX front end ----------------
  logic rx_meta_r, rx_sync_r, rx_prev_r;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        rx_wp_r, rx_rp_r;
  logic                 rx_full_s, rx_pop_s, rx_push_s;

  assign rx_empty  = (rx_wp_r == rx_rp_r);
  assign rx_full_s = (rx_wp_r[AW] != rx_rp_r[AW]) && (rx_wp_r[AW-1:0] == rx_rp_r[AW-1:0]);
  assign rx_pop_s  = rx_rd && !rx_empty;
  assign rx_data   = rx_empty ? {DATA_BITS{1'b0}} : rx_mem_r[rx_rp_r[AW-1:0]];

  // ---------------- RX engine ----------------
  logic [2:0]           rx_state_r;
  logic [OS_W-1:0]      rx_os_r;
  logic [BIT_W-1:0]     rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic                 rx_half_s, rx_bit_end_s;
  logic                 rx_ovr_set_s, rx_frm_set_s, rx_par_bad_s;
  logic                 rx_overrun_r, rx_frame_err_r;
`ifdef UART_PARITY_EN
  logic                 rx_par_r, rx_par_set_s, rx_parity_err_r;
`endif

  assign rx_half_s    = tick_s && (rx_os_r == OS_W'(OVERSAMPLE / 2 - 1));
  assign rx_bit_end_s = tick_s && (rx_os_r == OS_W'(OVERSAMPLE - 1));

  // Stop-bit verdict: push the byte or raise the matching error.
  always_comb begin
    rx_push_s    = 1'b0;
    rx_ovr_set_s = 1'b0;
    rx_frm_set_s = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_set_s = 1'b0;
    rx_par_bad_s = (rx_par_r != even_parity(rx_shift_r));
`else
    rx_par_bad_s = 1'b0;
`endif
    if (rx_state_r == S_STOP && rx_bit_end_s) begin
      if (!rx_sync_r) begin
        rx_frm_set_s = 1'b1;
`ifdef UART_PARITY_EN
        rx_par_set_s = rx_par_bad_s;
`endif
      end else if (rx_par_bad_s) begin
`ifdef UART_PARITY_EN
        rx_par_set_s = 1'b1;
`endif
      end else if (rx_full_s) begin
        rx_ovr_set_s = 1'b1;
      end else begin
        rx_push_s = 1'b1;
      end
    end else begin
      rx_push_s = 1'b0;
    end
  end

  // RX FIFO storage write.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wp_r[AW-1:0]] <= rx_shift_r;
  end

  // RX FIFO pointers; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp_r <= {PW{1'b0}};
      rx_rp_r <= {PW{1'b0}};
    end else begin
      if (rx_push_s) rx_wp_r <= rx_wp_r + PW'(1);
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + PW'(1);
    end
  end

  // RX frame sequencer: glitch-filtered start, mid-bit sampling LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= S_IDLE;
      rx_os_r    <= {OS_W{1'b0}};
      rx_bit_r   <= {BIT_W{1'b0}};
      rx_shift_r <= {DATA_BITS{1'b0}};
`ifdef UART_PARITY_EN
      rx_par_r   <= 1'b0;
`endif
    end else begin
      case (rx_state_r)
        S_IDLE: begin
          if (rx_prev_r && !rx_sync_r) begin
            rx_os_r    <= {OS_W{1'b0}};
            rx_state_r <= S_START;
          end
        end
        S_START: begin
          if (rx_half_s) begin
            rx_os_r  <= {OS_W{1'b0}};
            rx_bit_r <= {BIT_W{1'b0}};
            rx_state_r <= rx_sync_r ? S_IDLE : S_DATA;
          end else if (tick_s) rx_os_r <= rx_os_r + OS_W'(1);
        end
        S_DATA: begin
          if (rx_bit_end_s) begin
            rx_os_r    <= {OS_W{1'b0}};
            rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
            if (rx_bit_r == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_r <= S_PARITY;
`else
              rx_state_r <= S_STOP;
`endif
            end else begin
              rx_bit_r <= rx_bit_r + BIT_W'(1);
            end
          end else if (tick_s) rx_os_r <= rx_os_r + OS_W'(1);
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (rx_bit_end_s) begin
            rx_os_r    <= {OS_W{1'b0}};
            rx_par_r   <= rx_sync_r;
            rx_state_r <= S_STOP;
          end else if (tick_s) rx_os_r <= rx_os_r + OS_W'(1);
        end
`endif
        S_STOP: begin
          if (rx_bit_end_s) begin
            rx_os_r    <= {OS_W{1'b0}};
            rx_state_r <= rx_sync_r ? S_IDLE : S_WAIT;
          end else if (tick_s) rx_os_r <= rx_os_r + OS_W'(1);
        end
        S_WAIT: begin
          if (rx_sync_r) rx_state_r <= S_IDLE;
        end
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun_r    <= 1'b0;
      rx_frame_err_r  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err_r <= 1'b0;
`endif
    end else begin
      rx_overrun_r    <= (rx_overrun_r & ~err_clr) | rx_ovr_set_s;
      rx_frame_err_r  <= (rx_frame_err_r & ~err_clr) | rx_frm_set_s;
`ifdef UART_PARITY_EN
      rx_parity_err_r <= (rx_parity_err_r & ~err_clr) | rx_par_set_s;
`endif
    end
  end

  assign rx_overrun   = rx_overrun_r;
  assign rx_frame_err = rx_frame_err_r;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_parity_err_r;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: stimulus pushes expected bytes into
// queues, independent monitors decode tx and observe rx pops and compare.
module tb_uart_fifo_core;
  localparam int DB    = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_line, rx_drv = 1'b1, loop_en = 1'b0;
  logic       tx, tx_wr = 1'b0, tx_full, tx_busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       rx_rd = 1'b0, rx_empty, rx_overrun, rx_frame_err, err_clr = 1'b0;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int full_cnt = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] lb_vals [3] = '{8'h00, 8'hFF, 8'h3C};
  logic [7:0] ov_vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  uart_fifo_core #(.CLK_HZ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
                   .DATA_BITS(DB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx(rx_line), .tx(tx),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
`ifdef UART_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .err_clr(err_clr));

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_tx_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    else if (b <= DB) return d[b-1];
`ifdef UART_PARITY_EN
    else if (b == DB + 1) return ^d;
`endif
    else return 1'b1;
  endfunction

  task automatic write_tx(input logic [7:0] b);
    step();
    tx_data = b;
    tx_wr = 1'b1;
    tx_exp_q.push_back(b);
    step();
    tx_wr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (16) step();
    for (int i = 0; i < DB; i++) begin
      rx_drv = b[i];
      repeat (16) step();
    end
`ifdef UART_PARITY_EN
    rx_drv = ^b;
    repeat (16) step();
`endif
    rx_drv = stop_bit;
    repeat (16) step();
    rx_drv = 1'b1;
  endtask

  task automatic pop_rx();
    int w = 0;
    while (rx_empty && w < 2000) begin
      step();
      w++;
    end
    check("pop_wait_nonempty", rx_empty, 1'b0);
    if (!rx_empty) begin
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
    end
  endtask

  // RX monitor: compare every accepted pop against the scoreboard.
  always @(negedge clk) begin
    if (rx_rd === 1'b1 && rx_empty === 1'b0) begin
      if (rx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: popped 0x%0h with nothing expected", rx_data);
      end else begin
        check("rx_data", rx_data, rx_exp_q.pop_front());
      end
    end
  end

  // tx_full must never assert in any scenario of this bench.
  always @(negedge clk) begin
    if (tx_full === 1'b1) full_cnt++;
  end

  // TX monitor: decode frames on tx mid-bit; a reset aborts and flushes.
  initial begin : tx_mon
    logic [7:0] got;
    logic       abort, start_bit, stop_bit;
`ifdef UART_PARITY_EN
    logic       par_bit;
`endif
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        abort = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (reset) abort = 1'b1; end
        start_bit = tx;
        for (int b = 0; b < DB; b++) begin
          for (int k = 0; k < 16; k++) begin @(negedge clk); if (reset) abort = 1'b1; end
          got[b] = tx;
        end
`ifdef UART_PARITY_EN
        for (int k = 0; k < 16; k++) begin @(negedge clk); if (reset) abort = 1'b1; end
        par_bit = tx;
`endif
        for (int k = 0; k < 16; k++) begin @(negedge clk); if (reset) abort = 1'b1; end
        stop_bit = tx;
        if (abort) begin
          tx_exp_q.delete();
        end else begin
          check("tx_start_bit", start_bit, 1'b0);
          check("tx_stop_bit", stop_bit, 1'b1);
`ifdef UART_PARITY_EN
          check("tx_parity_bit", par_bit, ^got);
`endif
          if (tx_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: frame 0x%0h with nothing expected", got);
          end else begin
            check("tx_byte", got, tx_exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad, busy_bad, low_cnt, w;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_frame_err", rx_frame_err, 1'b0);
    step();
    reset = 1'b0;
    repeat (4) step();

    // Single TX frame 0xA5: exact bit timing and tx_busy window
    write_tx(8'hA5);
    @(negedge clk);
    check("tx_busy_after_wr", tx_busy, 1'b1);
    check("tx_high_before_start", tx, 1'b1);
    busy_bad = 0;
    for (int b = 0; b < NBITS; b++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (tx !== exp_tx_bit(8'hA5, b)) bad++;
        if (tx_busy !== 1'b1) busy_bad++;
      end
      check($sformatf("tx_a5_bit%0d_bad_cycles", b), bad, 0);
    end
    check("tx_busy_during_frame", busy_bad, 0);
    @(negedge clk);
    check("tx_busy_after_stop", tx_busy, 1'b0);
    check("tx_idle_after_stop", tx, 1'b1);
    repeat (20) step();

    // Loopback: three back-to-back bytes
    loop_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      tx_data = lb_vals[i];
      tx_wr = 1'b1;
      tx_exp_q.push_back(lb_vals[i]);
      rx_exp_q.push_back(lb_vals[i]);
      step();
    end
    tx_wr = 1'b0;
    for (int i = 0; i < 3; i++) pop_rx();
    w = 0;
    while (tx_busy && w < 500) begin step(); w++; end
    check("lb_tx_idle", tx_busy, 1'b0);
    check("lb_overrun", rx_overrun, 1'b0);
    check("lb_frame_err", rx_frame_err, 1'b0);
    check("lb_rx_empty", rx_empty, 1'b1);
    repeat (20) step();
    loop_en = 1'b0;
    repeat (20) step();

    // Overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp_q.push_back(ov_vals[i]);
      send_rx(ov_vals[i], 1'b1);
      repeat (4) step();
      if (i == 3) check("ovr_clear_after_4", rx_overrun, 1'b0);
    end
    check("ovr_set_after_5", rx_overrun, 1'b1);
    check("ovr_fifo_nonempty", rx_empty, 1'b0);
    for (int i = 0; i < 4; i++) pop_rx();
    check("ovr_empty_after_4_pops", rx_empty, 1'b1);
    rx_rd = 1'b1;
    step();
    rx_rd = 1'b0;
    step();
    check("rd_on_empty_ignored", rx_empty, 1'b1);
    check("ovr_sticky", rx_overrun, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_cleared", rx_overrun, 1'b0);

    // Framing error: 0x55 with a low stop bit
    send_rx(8'h55, 1'b0);
    repeat (8) step();
    check("frm_err_set", rx_frame_err, 1'b1);
    check("frm_no_push", rx_empty, 1'b1);
    check("frm_no_overrun", rx_overrun, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("frm_err_cleared", rx_frame_err, 1'b0);

    // Glitch: 4-cycle low pulse is rejected, then a good frame is accepted
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (64) step();
    check("glitch_no_push", rx_empty, 1'b1);
    check("glitch_no_frame_err", rx_frame_err, 1'b0);
    check("glitch_no_overrun", rx_overrun, 1'b0);
    rx_exp_q.push_back(8'h96);
    send_rx(8'h96, 1'b1);
    pop_rx();

    // Reset during TX data bit 3 with two bytes still queued
    step();
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'hC3 + 8'(i);
      tx_wr = 1'b1;
      tx_exp_q.push_back(8'hC3 + 8'(i));
      step();
    end
    tx_wr = 1'b0;
    repeat (69) step();
    check("pre_reset_busy", tx_busy, 1'b1);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_tx_busy", tx_busy, 1'b0);
    check("midrst_tx_full", tx_full, 1'b0);
    check("midrst_rx_empty", rx_empty, 1'b1);
    step();
    reset = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("post_reset_tx_quiet", low_cnt, 0);
    check("post_reset_busy", tx_busy, 1'b0);

    check("tx_full_never", full_cnt, 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("rx_queue_drained", rx_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
